// File: rtl/cnt_step_decoder.sv
// -----------------------------------------------------------------------------
// cnt_step_decoder
//
// Purpose:
//   Watches the output of a counter that advances each sample by either an
//   increment (prev+1) or a rotate-left (prev rotated by one bit). For each
//   valid sample it recovers which step was taken (the hidden control bit).
//   It flags samples that fit both steps (ambiguous) or neither step (error).
//   A two-state lock FSM (LOCKED / UNLOCKED) tracks whether the observed
//   stream is consistent with the counter model.
//
// Parameters:
//   LOSS_THRESH  consecutive mismatches while LOCKED that force UNLOCKED (1..15)
//   LOCK_THRESH  consecutive matches while UNLOCKED that restore LOCKED  (1..15)
//
// Ports:
//   clk        in   1   single clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   in_value holds a counter sample this cycle
//   in_value   in   8   observed counter output
//   dec_valid  out  1   one-cycle pulse, decoded result present (latency 1)
//   dec_bit    out  1   recovered bit: 1 = rotate-left, 0 = increment
//   dec_ambig  out  1   sample matched both candidate steps
//   dec_err    out  1   sample matched neither candidate step
//   locked     out  1   FSM is in LOCKED
//   err_count  out  16  saturating count of mismatches seen while LOCKED
//
// Configuration macro:
//   CNT_STEP_DECODER_ERRCNT_EN  defined   -> err_count counter is built
//                               undefined -> err_count tied to 16'h0000
// -----------------------------------------------------------------------------
module cnt_step_decoder #(
   parameter int LOSS_THRESH = 3,
   parameter int LOCK_THRESH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_value,
   output logic        dec_valid,
   output logic        dec_bit,
   output logic        dec_ambig,
   output logic        dec_err,
   output logic        locked,
   output logic [15:0] err_count
);

   localparam logic [3:0] LOSS_T = 4'(LOSS_THRESH);
   localparam logic [3:0] LOCK_T = 4'(LOCK_THRESH);

   typedef enum logic {
      ST_LOCKED   = 1'b0,
      ST_UNLOCKED = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_run;
   logic [3:0]  w_run_nxt;
   logic [3:0]  w_run_inc;

   logic [7:0]  r_prev;
   logic [7:0]  w_cand_inc;
   logic [7:0]  w_cand_rot;
   logic        w_m_inc;
   logic        w_m_rot;
   logic        w_miss;

   logic        r_dec_valid_p1;
   logic        r_dec_bit_p1;
   logic        r_dec_ambig_p1;
   logic        r_dec_err_p1;

   // ---- stage p0: candidate generation and classification (combinational)
   assign w_cand_inc = r_prev + 8'd1;            // 0xFF wraps to 0x00
   assign w_cand_rot = {r_prev[6:0], r_prev[7]};
   assign w_m_inc    = (in_value == w_cand_inc);
   assign w_m_rot    = (in_value == w_cand_rot);
   assign w_miss     = ~(w_m_inc | w_m_rot);
   assign w_run_inc  = r_run + 4'd1;

   // ---- FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_LOCKED;
         r_run   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= w_run_nxt;
      end
   end

   // ---- FSM next-state logic; run is cleared on every state change
   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = r_run;
      if (in_valid) begin
         case (r_state)
            ST_LOCKED: begin
               if (w_miss) begin
                  if (w_run_inc == LOSS_T) begin
                     w_state_nxt = ST_UNLOCKED;
                     w_run_nxt   = 4'd0;
                  end else begin
                     w_run_nxt = w_run_inc;
                  end
               end else begin
                  // ambiguous samples count as matches
                  w_run_nxt = 4'd0;
               end
            end
            ST_UNLOCKED: begin
               if (!w_miss) begin
                  if (w_run_inc == LOCK_T) begin
                     w_state_nxt = ST_LOCKED;
                     w_run_nxt   = 4'd0;
                  end else begin
                     w_run_nxt = w_run_inc;
                  end
               end else begin
                  w_run_nxt = 4'd0;
               end
            end
         endcase
      end
   end

   // ---- FSM output logic: locked comes straight from the state register,
   // so it changes on the same edge that dec_valid reports the causing sample
   always_comb begin
      locked = (r_state == ST_LOCKED);
   end

   // ---- stage p1: registered decode results and sample history
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev         <= 8'h00;
         r_dec_valid_p1 <= 1'b0;
         r_dec_bit_p1   <= 1'b0;
         r_dec_ambig_p1 <= 1'b0;
         r_dec_err_p1   <= 1'b0;
      end else begin
         r_dec_valid_p1 <= in_valid;
         if (in_valid) begin
            // prev follows every sample, even mismatches, to resynchronise
            r_prev         <= in_value;
            r_dec_bit_p1   <= w_m_rot & ~w_m_inc;
            r_dec_ambig_p1 <= w_m_rot & w_m_inc;
            r_dec_err_p1   <= w_miss;
         end
      end
   end

   assign dec_valid = r_dec_valid_p1;
   assign dec_bit   = r_dec_bit_p1;
   assign dec_ambig = r_dec_ambig_p1;
   assign dec_err   = r_dec_err_p1;

`ifdef CNT_STEP_DECODER_ERRCNT_EN
   logic [15:0] r_err_count_p1;
   logic        w_err_cnt_en;

   function automatic logic [15:0] sat_inc16(input logic [15:0] val);
      return (val == 16'hFFFF) ? val : val + 16'd1;
   endfunction

   // includes the mismatch that moves the FSM to UNLOCKED
   assign w_err_cnt_en = in_valid & w_miss & (r_state == ST_LOCKED);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_count_p1 <= 16'h0000;
      end else if (w_err_cnt_en) begin
         r_err_count_p1 <= sat_inc16(r_err_count_p1);
      end
   end

   assign err_count = r_err_count_p1;
`else
   assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cnt_step_decoder.sv
// -----------------------------------------------------------------------------
// tb_cnt_step_decoder
//
// Purpose: directed self-checking bench for cnt_step_decoder with default
// thresholds (LOSS_THRESH=3, LOCK_THRESH=2). Expected values are hand-derived
// from the counter model; err_count expectations follow the
// CNT_STEP_DECODER_ERRCNT_EN macro.
// -----------------------------------------------------------------------------
module tb_cnt_step_decoder;

`ifdef CNT_STEP_DECODER_ERRCNT_EN
   localparam bit ERRCNT_ON = 1'b1;
`else
   localparam bit ERRCNT_ON = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_value;
   logic        dec_valid;
   logic        dec_bit;
   logic        dec_ambig;
   logic        dec_err;
   logic        locked;
   logic [15:0] err_count;

   int n_cmp = 0;
   int n_bad = 0;
   int n_pulse;

   cnt_step_decoder #(
      .LOSS_THRESH (3),
      .LOCK_THRESH (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_value  (in_value),
      .dec_valid (dec_valid),
      .dec_bit   (dec_bit),
      .dec_ambig (dec_ambig),
      .dec_err   (dec_err),
      .locked    (locked),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] ec(input int n);
      return ERRCNT_ON ? 16'(n) : 16'h0000;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      chk(tag, {15'd0, obs}, {15'd0, exp});
   endtask

   // drive one cycle, then sample #1 after the edge that registered it
   task automatic cyc(input logic v, input logic [7:0] val);
      in_valid = v;
      in_value = val;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_value = 8'h00;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // checks dec_valid=1 plus bit/ambig/err of the sample just reported
   task automatic chk_dec(input string tag, input logic b, input logic a, input logic e);
      chk1({tag, ".valid"}, dec_valid, 1'b1);
      chk1({tag, ".bit"},   dec_bit,   b);
      chk1({tag, ".ambig"}, dec_ambig, a);
      chk1({tag, ".err"},   dec_err,   e);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_value = 8'h00;
      repeat (2) @(posedge clk);
      #1;

      // reset state
      do_reset();
      chk1("rst.valid",  dec_valid, 1'b0);
      chk1("rst.bit",    dec_bit,   1'b0);
      chk1("rst.ambig",  dec_ambig, 1'b0);
      chk1("rst.err",    dec_err,   1'b0);
      chk1("rst.locked", locked,    1'b1);
      chk ("rst.errcnt", err_count, 16'h0000);

      // 0x00 is rot of 0x00, 0x01 is inc of 0x00, 0x02 is both from 0x01
      cyc(1'b1, 8'h00); chk_dec("s00", 1'b1, 1'b0, 1'b0); chk1("s00.locked", locked, 1'b1);
      cyc(1'b1, 8'h01); chk_dec("s01", 1'b0, 1'b0, 1'b0); chk1("s01.locked", locked, 1'b1);
      cyc(1'b1, 8'h02); chk_dec("amb", 1'b0, 1'b1, 1'b0);

      // ambiguous sample clears the loss run
      do_reset();
      cyc(1'b1, 8'h55); chk_dec("runA", 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 8'h01); chk_dec("runB", 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 8'h02); chk_dec("runAmb", 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 8'h55); chk1("runC.err", dec_err, 1'b1);
      cyc(1'b1, 8'h00); chk1("runD.err", dec_err, 1'b1);
      chk1("runD.locked", locked, 1'b1);
      cyc(1'b1, 8'h55); chk1("runE.locked", locked, 1'b0);
      chk("runE.errcnt", err_count, ec(5));
      // mismatches while UNLOCKED are reported but not counted
      cyc(1'b1, 8'h00); chk1("unl.err", dec_err, 1'b1);
      chk("unl.errcnt", err_count, ec(5));

      // loss after three errors, relock after two matches
      do_reset();
      cyc(1'b1, 8'h00); chk_dec("lk0", 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 8'h55); chk1("lk1.err", dec_err, 1'b1); chk1("lk1.locked", locked, 1'b1);
      cyc(1'b1, 8'h00); chk1("lk2.err", dec_err, 1'b1); chk1("lk2.locked", locked, 1'b1);
      cyc(1'b1, 8'h55); chk1("lk3.err", dec_err, 1'b1); chk1("lk3.locked", locked, 1'b0);
      chk("lk3.errcnt", err_count, ec(3));
      cyc(1'b1, 8'h56); chk_dec("rl1", 1'b0, 1'b0, 1'b0); chk1("rl1.locked", locked, 1'b0);
      cyc(1'b1, 8'h57); chk_dec("rl2", 1'b0, 1'b0, 1'b0); chk1("rl2.locked", locked, 1'b1);
      chk("rl2.errcnt", err_count, ec(3));

      // drive to UNLOCKED, then reset collides with a valid sample
      cyc(1'b1, 8'h00);
      cyc(1'b1, 8'h55);
      cyc(1'b1, 8'h00); chk1("pre.locked", locked, 1'b0);
      chk("pre.errcnt", err_count, ec(6));
      rst      = 1'b1;
      in_valid = 1'b1;
      in_value = 8'h40;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      chk1("rc.locked", locked,    1'b1);
      chk1("rc.valid",  dec_valid, 1'b0);
      chk1("rc.err",    dec_err,   1'b0);
      chk ("rc.errcnt", err_count, 16'h0000);
      cyc(1'b1, 8'h01); chk_dec("rc.s01", 1'b0, 1'b0, 1'b0);

      // wrap cases
      cyc(1'b1, 8'hFF);
      cyc(1'b1, 8'h00); chk_dec("wFF_00", 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'hFF);
      cyc(1'b1, 8'hFF); chk_dec("wFF_FF", 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 8'h80);
      cyc(1'b1, 8'h01); chk_dec("w80_01", 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 8'h80);
      cyc(1'b1, 8'h81); chk_dec("w80_81", 1'b0, 1'b0, 1'b0);

      // gap of five idle cycles; junk on in_value must not disturb prev
      n_pulse = 0;
      cyc(1'b1, 8'h10); if (dec_valid) n_pulse++;
      chk_dec("gap0", 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 8'h20); if (dec_valid) n_pulse++;
         chk1("gap.valid", dec_valid, 1'b0);
      end
      chk1("gap.err_hold", dec_err, 1'b1);
      cyc(1'b1, 8'h11); if (dec_valid) n_pulse++;
      chk_dec("gap1", 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00); if (dec_valid) n_pulse++;
      chk("gap.pulses", 16'(n_pulse), 16'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cnt_step_decoder.md
CNT_STEP_DECODER -- requirements
Module: cnt_step_decoder

Interface
REQ-001 Parameter LOSS_THRESH, default 3: consecutive mismatches in LOCKED that force UNLOCKED; legal range 1..15.
REQ-002 Parameter LOCK_THRESH, default 2: consecutive matches in UNLOCKED that restore LOCKED; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_value carries one counter output sample this cycle.
REQ-006 in_value  input  8  observed counter output; each sample is prev+1 or rotate-left(prev).
REQ-007 dec_valid  output  1  one-cycle pulse: decoded result is present.
REQ-008 dec_bit  output  1  recovered control bit: 1 = rotate-left step, 0 = increment step.
REQ-009 dec_ambig  output  1  sample matched both candidate steps.
REQ-010 dec_err  output  1  sample matched neither candidate step.
REQ-011 locked  output  1  decoder is in state LOCKED.
REQ-012 err_count  output  16  saturating count of mismatches seen while LOCKED; see Configuration.

Function
REQ-013 Register prev (8 bits) SHALL hold the last accepted sample and SHALL reset to 0x00, the counter's own reset value.
REQ-014 Candidates SHALL be computed modulo 256: inc = prev+1 (0xFF wraps to 0x00); rot = {prev[6:0], prev[7]}.
REQ-015 On a cycle with in_valid=1 the block SHALL classify in_value:
  - matches rot only: dec_bit=1.
  - matches inc only: dec_bit=0.
  - matches both (only possible when prev=0x01 and in_value=0x02): dec_bit=0, dec_ambig=1.
  - matches neither: dec_bit=0, dec_err=1.
REQ-016 All outputs SHALL be registered, with latency exactly 1 cycle from the in_valid cycle to dec_valid.
REQ-017 When in_valid=0 the block SHALL drive dec_valid=0 on the next cycle; dec_bit, dec_ambig and dec_err SHALL hold their last values, and prev and the FSM SHALL hold.
REQ-018 prev SHALL load in_value on every valid sample, including mismatches, so decoding resynchronises to the observed stream.
REQ-019 The FSM SHALL have two states, LOCKED (reset state) and UNLOCKED, with a 4-bit run counter that is cleared on every state change.
REQ-020 In LOCKED: each mismatch increments run; each match or ambiguous sample clears run; when run reaches LOSS_THRESH the FSM SHALL move to UNLOCKED.
REQ-021 In UNLOCKED: each match or ambiguous sample increments run; each mismatch clears run; when run reaches LOCK_THRESH the FSM SHALL move to LOCKED.
REQ-022 dec_err SHALL be reported in both states; err_count SHALL increment only on mismatches classified while LOCKED, including the mismatch that causes the move to UNLOCKED.
REQ-023 err_count SHALL saturate at 0xFFFF and never wrap.
REQ-024 locked SHALL reflect the FSM state register, updating in the same cycle that dec_valid reports the sample that caused the transition.

Reset
REQ-025 While rst=1 at a clock edge: prev=0x00, FSM=LOCKED, run=0, dec_valid=0, dec_bit=0, dec_ambig=0, dec_err=0, locked=1, err_count=0.
REQ-026 rst SHALL take priority over a simultaneous in_valid; that sample SHALL be discarded.
REQ-027 A reset in UNLOCKED or mid-stream SHALL return the block to LOCKED with prev=0x00 on the next cycle.

Configuration
REQ-028 Macro CNT_STEP_DECODER_ERRCNT_EN defined: err_count SHALL be implemented as specified in REQ-012, REQ-022 and REQ-023.
REQ-029 Macro undefined: no counter register SHALL exist, err_count SHALL be tied to 16'h0000, and all other behaviour SHALL be unchanged.

Verification
REQ-030 Reset, then samples 0x00, 0x01 -> first sample dec_bit=1 (rot of 0x00); second sample dec_bit=0 (inc); no err; locked=1.
REQ-031 prev=0x01, sample 0x02 -> dec_ambig=1, dec_bit=0, dec_err=0; run cleared.
REQ-032 Wrap cases: prev=0xFF, sample 0x00 -> dec_bit=0; prev=0xFF, sample 0xFF -> dec_bit=1; prev=0x80, sample 0x01 -> dec_bit=1; prev=0x80, sample 0x81 -> dec_bit=0.
REQ-033 Defaults (LOSS_THRESH=3, LOCK_THRESH=2), samples 0x00, 0x55, 0x00, 0x55 -> the 0x55, 0x00, 0x55 samples each give dec_err=1; locked drops with the third error; err_count=3 (macro on) or 0 (macro off); then samples 0x56, 0x57 -> locked=1 with the second match.
REQ-034 Gaps: in_valid low for 5 cycles between samples 0x10 and 0x11 -> dec_valid pulses exactly twice; second pulse gives dec_bit=0, no err.
REQ-035 rst asserted in the same cycle as in_valid with in_value=0x40 while UNLOCKED -> sample ignored; next cycle locked=1 and err_count=0; then sample 0x01 -> dec_bit=0, no err.
